// File: rtl/hbridge_deadtime_driver_pkg.sv
// Shared definitions for the H-bridge dead-time gate driver: state encoding,
// gate vector bit positions and default sizing.
package hbridge_deadtime_driver_pkg;

  localparam int DEAD_WIDTH_DEF   = 8;
  localparam int FAULT_FILTER_DEF = 3;

  localparam int HS_A = 3;
  localparam int LS_A = 2;
  localparam int HS_B = 1;
  localparam int LS_B = 0;

  typedef enum logic [2:0] {
    ST_COAST = 3'd0,
    ST_BRAKE = 3'd1,
    ST_FWD   = 3'd2,
    ST_REV   = 3'd3,
    ST_DEAD  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // Gate vector {hs_a, ls_a, hs_b, ls_b} driven while sitting in a state.
  function automatic logic [3:0] gates_of(input state_e s);
    logic [3:0] g;
    g = '0;
    case (s)
      ST_FWD:   begin g[HS_A] = 1'b1; g[LS_B] = 1'b1; end
      ST_REV:   begin g[HS_B] = 1'b1; g[LS_A] = 1'b1; end
      ST_BRAKE: begin g[LS_A] = 1'b1; g[LS_B] = 1'b1; end
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hbridge_deadtime_driver_sync_filter.sv
// Shift-register agreement filter: output goes high when all samples are 1,
// low when all are 0, and holds its last value while the samples disagree.
module sync_filter #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  output logic level
);

  logic [DEPTH-1:0] shreg;
  logic             held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      held  <= 1'b0;
    end else begin
      shreg <= (shreg << 1) | DEPTH'(sample);
      held  <= level;
    end
  end

  always_comb begin
    level = held;
    if (&shreg)       level = 1'b1;
    else if (~|shreg) level = 1'b0;
  end

endmodule

// File: rtl/hbridge_deadtime_driver.sv
// H-bridge gate driver: turns PWM direction commands into four gate drives with
// programmable dead time before any turn-on, brake/coast off-state and a latched fault.
module hbridge_deadtime_driver
  import hbridge_deadtime_driver_pkg::*;
#(
  parameter int DEAD_WIDTH   = DEAD_WIDTH_DEF,
  parameter int FAULT_FILTER = FAULT_FILTER_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  input  logic                  motor_positive,
  input  logic                  motor_negative,
  input  logic                  brake_en,
  input  logic                  fault_n,
  input  logic                  fault_clear,
  output logic                  hs_a,
  output logic                  ls_a,
  output logic                  hs_b,
  output logic                  ls_b,
  output logic                  fault_latched,
  output logic [2:0]            state_o
);

  logic [1:0]            cmd_q;
  logic                  cmd_off;
  logic                  fault;
  state_e                state, state_nxt, tgt, tgt_q, tgt_nxt;
  logic [DEAD_WIDTH-1:0] cnt, cnt_nxt, dead_load;
  logic [3:0]            gates;

  // Filter the active-high fault so the cleared register means "no fault".
  sync_filter #(.DEPTH(FAULT_FILTER)) u_fault_filter (
    .clk   (clk),
    .rst_n (reset),
    .sample(~fault_n),
    .level (fault)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cmd_q <= 2'b00;
    else        cmd_q <= {motor_positive, motor_negative};
  end

  // Both-high is illegal and falls into the off case together with both-low.
  assign cmd_off = (cmd_q[1] == cmd_q[0]);

  always_comb begin
    case (cmd_q)
      2'b10:   tgt = ST_FWD;
      2'b01:   tgt = ST_REV;
      default: tgt = brake_en ? ST_BRAKE : ST_COAST;
    endcase
  end

  // Counter is loaded with N-1 so that exactly N cycles are spent in DEAD.
  assign dead_load = (dead_time == '0) ? '0 : dead_time - DEAD_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    cnt_nxt   = cnt;
    if (fault) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_FAULT: if (fault_clear && cmd_off) state_nxt = ST_COAST;
        ST_DEAD: begin
          if (tgt != tgt_q) begin
            if (tgt == ST_COAST) begin
              state_nxt = ST_COAST;
            end else begin
              tgt_nxt = tgt;
              cnt_nxt = dead_load;
            end
          end else if (cnt == '0) begin
            state_nxt = tgt_q;
          end else begin
            cnt_nxt = cnt - DEAD_WIDTH'(1);
          end
        end
        default: begin
          if (tgt != state) begin
            if (tgt == ST_COAST) begin
              state_nxt = ST_COAST;
            end else begin
              state_nxt = ST_DEAD;
              tgt_nxt   = tgt;
              cnt_nxt   = dead_load;
            end
          end
        end
      endcase
    end
  end

  // Gates and fault flag are registered from the next state so they line up with state_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_COAST;
      tgt_q         <= ST_COAST;
      cnt           <= '0;
      gates         <= '0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_nxt;
      tgt_q         <= tgt_nxt;
      cnt           <= cnt_nxt;
      gates         <= gates_of(state_nxt);
      fault_latched <= (state_nxt == ST_FAULT);
    end
  end

  assign hs_a    = gates[HS_A];
  assign ls_a    = gates[LS_A];
  assign hs_b    = gates[HS_B];
  assign ls_b    = gates[LS_B];
  assign state_o = state;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Bench for hbridge_deadtime_driver: cycle-stamped expectations queued by the
// stimulus, popped and compared by a negedge monitor alongside shoot-through checks.
module tb_hbridge_deadtime_driver;

  localparam logic [2:0] S_COAST = 3'd0, S_BRAKE = 3'd1, S_FWD = 3'd2,
                         S_REV = 3'd3, S_DEAD = 3'd4, S_FAULT = 3'd5;
  localparam logic [3:0] G_OFF = 4'b0000, G_FWD = 4'b1001,
                         G_REV = 4'b0110, G_BRK = 4'b0101;

  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] dead_time = 8'd0;
  logic       pos = 1'b0, neg = 1'b0, brake_en = 1'b0;
  logic       fault_n = 1'b1, fault_clear = 1'b0;
  logic       hs_a, ls_a, hs_b, ls_b, fault_latched;
  logic [2:0] state_o;

  int cyc = 0, errors = 0, checks = 0;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [3:0] g;
    logic       f;
    string      name;
  } exp_t;
  exp_t sb[$];

  hbridge_deadtime_driver dut (
    .clk(clk), .reset(reset), .dead_time(dead_time),
    .motor_positive(pos), .motor_negative(neg), .brake_en(brake_en),
    .fault_n(fault_n), .fault_clear(fault_clear),
    .hs_a(hs_a), .ls_a(ls_a), .hs_b(hs_b), .ls_b(ls_b),
    .fault_latched(fault_latched), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // d = number of clock edges from now at which the expectation applies.
  task automatic expect_at(input int d, input logic [2:0] st, input logic [3:0] g,
                           input logic f, input string name);
    exp_t e;
    e.cyc = cyc + d; e.st = st; e.g = g; e.f = f; e.name = name;
    sb.push_back(e);
  endtask

  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if ({state_o, hs_a, ls_a, hs_b, ls_b, fault_latched} !== {e.st, e.g, e.f}) begin
        errors++;
        $display("FAIL %s @%0d: got state=%0d gates=%b fault=%b, want state=%0d gates=%b fault=%b",
                 e.name, cyc, state_o, {hs_a, ls_a, hs_b, ls_b}, fault_latched, e.st, e.g, e.f);
      end
    end
    if (reset) begin
      checks++;
      if ((hs_a & ls_a) | (hs_b & ls_b) | (hs_a & hs_b)) begin
        errors++;
        $display("FAIL shoot_through @%0d: got gates=%b, want no conflicting pair",
                 cyc, {hs_a, ls_a, hs_b, ls_b});
      end
    end
  end

  initial begin
    step(3);
    reset = 1'b1;
    expect_at(0, S_COAST, G_OFF, 1'b0, "reset_state");
    expect_at(2, S_COAST, G_OFF, 1'b0, "reset_idle");
    step(3);

    // Coast -> FWD with N=5, then immediate turn-off to coast.
    dead_time = 8'd5; pos = 1'b1;
    expect_at(1, S_COAST, G_OFF, 1'b0, "fwd_cmdq_only");
    expect_at(2, S_DEAD,  G_OFF, 1'b0, "fwd_dead_start");
    expect_at(6, S_DEAD,  G_OFF, 1'b0, "fwd_dead_end");
    expect_at(7, S_FWD,   G_FWD, 1'b0, "fwd_on");
    step(10);
    pos = 1'b0;
    expect_at(1, S_FWD,   G_FWD, 1'b0, "fwd_hold");
    expect_at(2, S_COAST, G_OFF, 1'b0, "fwd_off_coast");
    step(4);

    // N=4: FWD -> brake through dead time, then back to FWD.
    dead_time = 8'd4; pos = 1'b1;
    expect_at(2, S_DEAD, G_OFF, 1'b0, "fwd2_dead");
    expect_at(5, S_DEAD, G_OFF, 1'b0, "fwd2_dead_end");
    expect_at(6, S_FWD,  G_FWD, 1'b0, "fwd2_on");
    step(8);
    brake_en = 1'b1;
    step(2);
    pos = 1'b0;
    expect_at(1, S_FWD,   G_FWD, 1'b0, "brk_hold");
    expect_at(2, S_DEAD,  G_OFF, 1'b0, "brk_dead");
    expect_at(5, S_DEAD,  G_OFF, 1'b0, "brk_dead_end");
    expect_at(6, S_BRAKE, G_BRK, 1'b0, "brk_on");
    step(8);
    pos = 1'b1;
    expect_at(2, S_DEAD, G_OFF, 1'b0, "brk_fwd_dead");
    expect_at(5, S_DEAD, G_OFF, 1'b0, "brk_fwd_dead_end");
    expect_at(6, S_FWD,  G_FWD, 1'b0, "brk_to_fwd");
    step(8);

    // dead_time=0 acts as one cycle; illegal both-high behaves as off.
    brake_en = 1'b0; dead_time = 8'd0; pos = 1'b0; neg = 1'b1;
    expect_at(1, S_FWD,  G_FWD, 1'b0, "rev_hold_fwd");
    expect_at(2, S_DEAD, G_OFF, 1'b0, "rev_dead_min");
    expect_at(3, S_REV,  G_REV, 1'b0, "rev_on");
    step(5);
    pos = 1'b1;
    expect_at(1, S_REV,   G_REV, 1'b0, "illegal_hold");
    expect_at(2, S_COAST, G_OFF, 1'b0, "illegal_coast");
    step(3);
    brake_en = 1'b1;
    expect_at(1, S_DEAD,  G_OFF, 1'b0, "illegal_brake_dead");
    expect_at(2, S_BRAKE, G_BRK, 1'b0, "illegal_brake");
    step(4);
    pos = 1'b0; neg = 1'b0; brake_en = 1'b0;
    expect_at(1, S_COAST, G_OFF, 1'b0, "brake_release");
    step(3);

    // N=10: REV requested, FWD requested mid-dead restarts the count.
    dead_time = 8'd10; neg = 1'b1;
    expect_at(2,  S_DEAD, G_OFF, 1'b0, "restart_dead");
    expect_at(9,  S_DEAD, G_OFF, 1'b0, "restart_point");
    expect_at(12, S_DEAD, G_OFF, 1'b0, "restart_no_rev");
    expect_at(18, S_DEAD, G_OFF, 1'b0, "restart_dead_end");
    expect_at(19, S_FWD,  G_FWD, 1'b0, "restart_fwd_on");
    step(7);
    pos = 1'b1; neg = 1'b0;
    step(3);
    dead_time = 8'd2;
    step(12);

    // Fault filter: 2 low samples ignored, 3 latch the fault.
    fault_n = 1'b0;
    expect_at(4, S_FWD, G_FWD, 1'b0, "glitch_ignored");
    expect_at(5, S_FWD, G_FWD, 1'b0, "glitch_ignored2");
    step(2);
    fault_n = 1'b1;
    step(4);
    fault_n = 1'b0;
    expect_at(3, S_FWD,   G_FWD, 1'b0, "fault_pending");
    expect_at(4, S_FAULT, G_OFF, 1'b1, "fault_entry");
    step(6);
    fault_n = 1'b1;
    step(4);
    fault_clear = 1'b1;
    expect_at(2, S_FAULT, G_OFF, 1'b1, "clear_blocked_cmd");
    expect_at(3, S_FAULT, G_OFF, 1'b1, "clear_blocked_cmd2");
    step(3);
    pos = 1'b0;
    expect_at(1, S_FAULT, G_OFF, 1'b1, "clear_wait_cmdq");
    expect_at(2, S_COAST, G_OFF, 1'b0, "fault_exit");
    step(3);
    fault_clear = 1'b0; pos = 1'b1;
    expect_at(2, S_DEAD, G_OFF, 1'b0, "post_fault_dead");
    expect_at(3, S_DEAD, G_OFF, 1'b0, "post_fault_dead2");
    expect_at(4, S_FWD,  G_FWD, 1'b0, "post_fault_fwd");
    step(8);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hbridge_deadtime_driver.md
Name: hbridge_deadtime_driver

Overview:
Downstream stage of the BLDC speed/PID controller. Consumes the controller's motor_positive/motor_negative PWM commands and drives the four H-bridge gates (high/low side, legs A and B). It inserts a programmable dead time before any switch turns on, and optionally brakes or coasts when the command is off. It latches an external overcurrent fault that forces all gates off.

Parameters:
DEAD_WIDTH, 8, width of dead_time input and internal dead counter
FAULT_FILTER, 3, fault_n filter depth; fault is accepted only when this many consecutive samples agree

Ports:
clk  in  1  system clock, same clock as the PID/ESC stage
reset  in  1  asynchronous, active-low reset (0 = reset)
dead_time  in  DEAD_WIDTH  dead time in clk cycles; effective value is max(dead_time,1)
motor_positive  in  1  forward PWM command from the ESC stage
motor_negative  in  1  reverse PWM command from the ESC stage
brake_en  in  1  off-state select: 1 = low-side brake (ls_a=ls_b=1), 0 = coast (all gates 0)
fault_n  in  1  external overcurrent, active-low, asynchronous to logic
fault_clear  in  1  level request to leave FAULT
hs_a, ls_a, hs_b, ls_b  out  1 each  registered gate drives
fault_latched  out  1  1 while in FAULT
state_o  out  3  current FSM state encoding

Behaviour:
- Reset asserted: all gates 0, fault_latched 0, state COAST, dead counter 0, filter register and input registers cleared.
- Input stage: motor_positive/negative are registered once into cmd_q.
  - FWD = pos & ~neg; REV = neg & ~pos.
  - Both low: OFF. Both high: illegal, treated as OFF.
- Gate sets:
  - FWD: hs_a=1, ls_b=1
  - REV: hs_b=1, ls_a=1
  - BRAKE: ls_a=1, ls_b=1
  - COAST: all 0
  - FAULT and DEAD: all 0
- States: COAST, BRAKE, FWD, REV, DEAD, FAULT.
- Target state: FWD or REV from cmd_q; when cmd_q is OFF, BRAKE if brake_en else COAST.
- Transitions:
  - Target differs from the current state and the target is COAST: go to COAST at the next edge. No dead time; turn-off is always immediate.
  - Target differs and is conducting (FWD/REV/BRAKE): go to DEAD at the next edge, with all gates 0.
    - Latch the target and N = max(dead_time,1).
    - Count N cycles in DEAD, then enter the latched target.
  - Target changes during DEAD: restart the counter with the new target and freshly sampled N.
    - If the new target is COAST, leave DEAD to COAST immediately.
  - dead_time changes during DEAD do not affect the running count.
- Latency: with a command edge before clk edge k, cmd_q updates at k and gates go off at k+1. The new gates go high at edge k+1+N.
  - Every PWM on-pulse is therefore shortened by N cycles.
  - A pulse shorter than N+1 cycles produces no turn-on.
- Fault:
  - fault_n is sampled through a FAULT_FILTER-deep shift register. The filtered fault asserts when all samples are 0 and deasserts when all are 1 (hold otherwise).
  - Filtered fault asserted: FAULT from any state at the next edge; all gates 0; fault_latched=1. Fault has priority over every other transition.
  - Exit FAULT to COAST only when fault_clear=1, the filtered fault is inactive, and cmd_q is OFF, all in the same cycle. Otherwise stay in FAULT.
  - After exit, normal rules apply; any conducting target goes through DEAD.
- Invariants, checked every cycle: never hs_a&ls_a, never hs_b&ls_b, never hs_a&hs_b.
  - Any rising gate edge is preceded by at least N cycles with the same-leg complementary gate 0.
- state_o encoding: COAST 0, BRAKE 1, FWD 2, REV 3, DEAD 4, FAULT 5.

Decomposition:
- Shared package: state encoding constants, gate vector bit indices (HS_A=3, LS_A=2, HS_B=1, LS_B=0), and the default DEAD_WIDTH/FAULT_FILTER values.
- One sub-module: sync_filter (parameter DEPTH). It is a shift-register agreement filter with a held output, instantiated for fault_n. It is reusable for the encoder/pwm_en debounce elsewhere in the design.

Test Plan:
- Reset low, then high, with pos=neg=0 and brake_en=0 -> all gates 0, state_o=0, fault_latched=0.
- dead_time=5; pos rises before edge k -> gates 0 through edge k+5, hs_a=ls_b=1 at edge k+6. Pos falls -> gates 0 one edge after cmd_q updates, with no DEAD.
- dead_time=4, brake_en=1; FWD held, then pos falls -> hs_a/ls_b drop immediately, 4 cycles in DEAD, then ls_a=ls_b=1. Pos rises again -> DEAD for 4 cycles, then FWD.
- dead_time=0; FWD switches to REV -> exactly 1 cycle with all gates 0, then hs_b=ls_a=1. A pos=neg=1 input gives behaviour identical to OFF.
- dead_time=10; REV requested, and at DEAD count 6 FWD is requested -> counter restarts, FWD gates appear 10 cycles after the restart. Shoot-through assertions stay silent throughout.
- FWD active; fault_n low for 2 cycles -> no fault. Low for 3 cycles -> next edge all gates 0, fault_latched=1, state_o=5.
  - fault_clear=1 with pos=1 -> stays in FAULT.
  - pos=0 and fault_n high for 3 cycles, then fault_clear -> COAST.
